// File: rtl/sample_capture_writer.sv
// Writes one triggered frame of packed multichannel ADC samples into the sample BRAM, addresses 0..DEPTH-1.
// Optional: define CAPTURE_OVERRUN_EN for a sticky overrun flag and a saturating dropped-sample counter.
module sample_capture_writer #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 12,
   parameter int ADDR_W   = 11,
   parameter int DEPTH    = 2048
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arm,
   input  logic                         trigger,
   input  logic [3:0]                   decim,
   input  logic                         sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]   sample_in,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [CHANNELS*DATA_W-1:0]   mem_wdata,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         frame_ready,
   output logic [ADDR_W:0]              sample_count,
   output logic                         overrun
);

   localparam int SW = CHANNELS * DATA_W;
   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        decim_q, decim_cnt;
   logic [ADDR_W:0]   cnt_q;
   logic              busy_q, done_q, ready_q;
   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [SW-1:0]     wdata_p1;

   logic              start_cap, accept, last_wr;
   logic [ADDR_W-1:0] wr_ptr;

   // A valid sample coincident with the trigger is sample 0; once DEPTH samples
   // are accepted, nothing more is taken while the final write drains.
   assign start_cap = (state == S_ARMED) && trigger;
   assign accept    = sample_valid &&
                      (start_cap || ((state == S_CAPTURE) && (decim_cnt == 4'd0) && (cnt_q != FULL_CNT)));
   assign last_wr   = vld_p1 && (addr_p1 == LAST_ADDR);
   assign wr_ptr    = start_cap ? '0 : cnt_q[ADDR_W-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (arm)     state_nxt = S_ARMED;
         S_ARMED:   if (trigger) state_nxt = S_CAPTURE;
         S_CAPTURE: if (last_wr) state_nxt = S_DONE;
         S_DONE:    if (arm)     state_nxt = S_ARMED;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Stage p0 -> p1: accepted sample registered as a BRAM write
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
         decim_q   <= 4'd0;
         decim_cnt <= 4'd0;
         cnt_q     <= '0;
         vld_p1    <= 1'b0;
         addr_p1   <= '0;
         wdata_p1  <= '0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
         done_q <= (state == S_CAPTURE) && last_wr;
         if ((state == S_CAPTURE) && last_wr)
            ready_q <= 1'b1;
         else if ((state == S_DONE) && arm)
            ready_q <= 1'b0;
         vld_p1 <= accept;
         if (accept) begin
            addr_p1  <= wr_ptr;
            wdata_p1 <= sample_in;
         end
         if (start_cap) begin
            decim_q   <= decim;
            decim_cnt <= (sample_valid && (decim != 4'd0)) ? 4'd1 : 4'd0;
            cnt_q     <= accept ? (ADDR_W + 1)'(1) : '0;
         end else begin
            if (accept)
               cnt_q <= cnt_q + (ADDR_W + 1)'(1);
            if ((state == S_CAPTURE) && sample_valid)
               decim_cnt <= (decim_cnt == decim_q) ? 4'd0 : decim_cnt + 4'd1;
         end
      end
   end

   assign mem_we       = vld_p1;
   assign mem_addr     = addr_p1;
   assign mem_wdata    = wdata_p1;
   assign busy         = busy_q;
   assign frame_done   = done_q;
   assign frame_ready  = ready_q;
   assign sample_count = cnt_q;

`ifdef CAPTURE_OVERRUN_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        ovr_q;
   logic [15:0] drop_cnt;

   // Samples arriving while a finished frame waits to be consumed are lost.
   always_ff @(posedge clk) begin
      if (rst || ((state == S_DONE) && arm)) begin
         ovr_q    <= 1'b0;
         drop_cnt <= 16'd0;
      end else if ((state == S_DONE) && sample_valid) begin
         ovr_q    <= 1'b1;
         drop_cnt <= sat_inc16(drop_cnt);
      end
   end

   assign overrun = ovr_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed bench for sample_capture_writer at DEPTH=16, ADDR_W=4; expectations are hand-derived.
module tb_sample_capture_writer;

   localparam int SW = 48;

   logic          clk = 1'b0;
   logic          rst, arm, trigger, sample_valid;
   logic [3:0]    decim;
   logic [SW-1:0] sample_in;
   logic          mem_we, busy, frame_done, frame_ready, overrun;
   logic [3:0]    mem_addr;
   logic [SW-1:0] mem_wdata;
   logic [4:0]    sample_count;

   int n_cmp = 0;
   int n_err = 0;
   int n_we;

   sample_capture_writer #(.CHANNELS(4), .DATA_W(12), .ADDR_W(4), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .arm(arm), .trigger(trigger), .decim(decim),
      .sample_valid(sample_valid), .sample_in(sample_in),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .frame_done(frame_done), .frame_ready(frame_ready),
      .sample_count(sample_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; trigger = 1'b0; sample_valid = 1'b0; decim = 4'd0; sample_in = '0;
      tick(); tick();
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_addr",  64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(frame_done), 64'd0);
      chk("rst_ready", 64'(frame_ready), 64'd0);
      chk("rst_count", 64'(sample_count), 64'd0);
      chk("rst_ovr",   64'(overrun), 64'd0);

      // trigger while idle does nothing
      rst = 1'b0; trigger = 1'b1; sample_valid = 1'b1;
      tick();
      chk("idle_trig_busy", 64'(busy), 64'd0);
      chk("idle_trig_we",   64'(mem_we), 64'd0);
      trigger = 1'b0; sample_valid = 1'b0;

      // continuous capture, decim=0, arm pulsed mid-frame
      arm = 1'b1;
      tick();
      chk("armed_busy", 64'(busy), 64'd1);
      arm = 1'b0;
      n_we = 0;
      for (int k = 0; k <= 20; k++) begin
         sample_in = SW'(k); sample_valid = 1'b1; trigger = (k == 0); arm = (k == 5);
         tick();
         if (mem_we) n_we++;
         chk($sformatf("c_we%0d", k), 64'(mem_we), 64'(k < 16));
         chk($sformatf("c_done%0d", k), 64'(frame_done), 64'(k == 16));
         if (k < 16) begin
            chk($sformatf("c_addr%0d", k), 64'(mem_addr), 64'(k));
            chk($sformatf("c_data%0d", k), 64'(mem_wdata), 64'(k));
            chk($sformatf("c_cnt%0d", k), 64'(sample_count), 64'(k + 1));
         end
      end
      trigger = 1'b0; arm = 1'b0;
      chk("c_nwe",   64'(n_we), 64'd16);
      chk("c_ready", 64'(frame_ready), 64'd1);
      chk("c_count", 64'(sample_count), 64'd16);
      chk("c_busy",  64'(busy), 64'd0);

      // trigger in DONE, then samples arriving in DONE
      sample_valid = 1'b0; trigger = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("done_trig_we%0d", i), 64'(mem_we), 64'd0);
      end
      trigger = 1'b0; sample_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("done_valid_we%0d", i), 64'(mem_we), 64'd0);
      end
      sample_valid = 1'b0;
      tick();
      chk("done_count_held", 64'(sample_count), 64'd16);
`ifdef CAPTURE_OVERRUN_EN
      chk("ovr_set",  64'(overrun), 64'd1);
      chk("ovr_drop", 64'(dut.drop_cnt), 64'd3);
`else
      chk("ovr_off",  64'(overrun), 64'd0);
`endif
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("rearm_ready", 64'(frame_ready), 64'd0);
      chk("rearm_ovr",   64'(overrun), 64'd0);
      chk("rearm_busy",  64'(busy), 64'd1);
      chk("rearm_count", 64'(sample_count), 64'd16);

      // decimation by 3; decim change mid-frame must not take effect
      decim = 4'd2; n_we = 0;
      for (int k = 0; k <= 49; k++) begin
         sample_in = SW'(k); sample_valid = 1'b1; trigger = (k == 0);
         if (k == 10) decim = 4'd0;
         tick();
         if (mem_we) n_we++;
         chk($sformatf("d_we%0d", k), 64'(mem_we), 64'((k % 3 == 0) && (k <= 45)));
         chk($sformatf("d_done%0d", k), 64'(frame_done), 64'(k == 46));
         if ((k % 3 == 0) && (k <= 45)) begin
            chk($sformatf("d_addr%0d", k), 64'(mem_addr), 64'(k / 3));
            chk($sformatf("d_data%0d", k), 64'(mem_wdata), 64'(k));
         end
      end
      trigger = 1'b0; sample_valid = 1'b0;
      chk("d_nwe", 64'(n_we), 64'd16);

      // gapped valid
      decim = 4'd0; arm = 1'b1;
      tick();
      arm = 1'b0; n_we = 0;
      for (int j = 0; j <= 33; j++) begin
         sample_in = SW'(100 + j); sample_valid = (j % 2 == 0); trigger = (j == 0);
         tick();
         if (mem_we) n_we++;
         chk($sformatf("g_we%0d", j), 64'(mem_we), 64'((j % 2 == 0) && (j <= 30)));
         chk($sformatf("g_done%0d", j), 64'(frame_done), 64'(j == 31));
         if ((j % 2 == 0) && (j <= 30)) begin
            chk($sformatf("g_addr%0d", j), 64'(mem_addr), 64'(j / 2));
            chk($sformatf("g_data%0d", j), 64'(mem_wdata), 64'(100 + j));
            chk($sformatf("g_cnt%0d", j), 64'(sample_count), 64'(j / 2 + 1));
         end
      end
      trigger = 1'b0; sample_valid = 1'b0;
      chk("g_nwe", 64'(n_we), 64'd16);

      // reset after the 7th write of a frame
      arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         sample_in = SW'(200 + k); sample_valid = 1'b1; trigger = (k == 0);
         tick();
      end
      trigger = 1'b0;
      chk("r_7th_addr", 64'(mem_addr), 64'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("r_we",    64'(mem_we), 64'd0);
      chk("r_busy",  64'(busy), 64'd0);
      chk("r_count", 64'(sample_count), 64'd0);
      chk("r_done",  64'(frame_done), 64'd0);
      chk("r_ready", 64'(frame_ready), 64'd0);
      tick();
      chk("r_idle_we", 64'(mem_we), 64'd0);
      arm = 1'b1;
      tick();
      arm = 1'b0; trigger = 1'b1; sample_in = SW'(300);
      tick();
      trigger = 1'b0; sample_valid = 1'b0;
      chk("r2_we",   64'(mem_we), 64'd1);
      chk("r2_addr", 64'(mem_addr), 64'd0);
      chk("r2_data", 64'(mem_wdata), 64'd300);
      chk("r2_cnt",  64'(sample_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sample_capture_writer.md
Name: sample_capture_writer

Overview:
- Writer side of the beamformer sample memory: captures a frame of multichannel ADC samples after a trigger and writes them into the input-sample BRAM at addresses 0..DEPTH-1.
- The delay-and-sum beamformer reads from that BRAM by address.
- Signals frame completion so the beamformer `start` can be raised.
- Sits between the ADC/sample front end and the BRAM write port.

Parameters:
- CHANNELS, 4, number of microphone/ADC channels packed per sample word
- DATA_W, 12, bits per channel sample
- ADDR_W, 11, BRAM address width
- DEPTH, 2048, samples per frame; legal range 2..2^ADDR_W

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- arm  input  1  level/pulse; request a new capture frame
- trigger  input  1  start capture when armed
- decim  input  4  decimation factor minus one; 0 = keep every valid sample
- sample_valid  input  1  sample_in valid this cycle (no backpressure)
- sample_in  input  CHANNELS*DATA_W  packed channel samples, channel 0 in LSBs
- mem_we  output  1  BRAM write enable
- mem_addr  output  ADDR_W  BRAM write address
- mem_wdata  output  CHANNELS*DATA_W  BRAM write data
- busy  output  1  high in ARMED or CAPTURE
- frame_done  output  1  one-cycle pulse at frame completion
- frame_ready  output  1  level: complete frame in memory, not yet re-armed
- sample_count  output  ADDR_W+1  samples written in current/last frame
- overrun  output  1  see Optional Feature

Behaviour:
- Reset: state IDLE, decimation counter 0.
  - Outputs cleared: mem_we, mem_addr, mem_wdata, busy, frame_done, frame_ready, sample_count, overrun.
  - rst mid-capture: next cycle mem_we=0, IDLE, no frame_done, frame_ready=0.
- States and transitions:
  - IDLE: arm=1 -> ARMED. trigger ignored.
  - ARMED:
    - trigger=1 -> CAPTURE.
    - On entry to CAPTURE: sample_count cleared, address pointer set to 0, decimation counter set to 0.
    - A sample_valid in the same cycle as trigger is accepted as sample 0.
  - CAPTURE:
    - Accepted sample = sample_valid && decim_cnt==0.
    - decim_cnt advances on every sample_valid, wrapping from decim to 0. It is held when sample_valid=0.
    - Each accepted sample produces, on the next cycle (latency 1):
      - mem_we=1;
      - mem_addr = pointer;
      - mem_wdata = registered sample_in;
      - sample_count incremented.
    - mem_we is high for exactly one cycle per accepted sample and 0 otherwise.
    - After the write to address DEPTH-1 is issued, go to DONE. frame_done pulses in the cycle immediately after that write. frame_ready rises in the same cycle and stays high.
    - arm and trigger ignored.
  - DONE:
    - arm=1 -> ARMED, frame_ready cleared next cycle, sample_count held until trigger.
    - sample_valid and trigger ignored, no writes.
- Address never wraps within a frame. Each frame restarts at 0. Addresses are strictly increasing by 1.
- decim sampled only on entry to CAPTURE; changes mid-frame take effect next frame.
- busy = (state==ARMED || state==CAPTURE), registered.
- frame_done and mem_we never both high in the same cycle.

Optional Feature:
- Macro: CAPTURE_OVERRUN_EN.
- When defined:
  - overrun is a sticky flag, set when sample_valid=1 while in DONE (frame not consumed before new data arrives).
  - Cleared on arm (the transition DONE->ARMED) or rst.
  - A 16-bit saturating internal counter of dropped samples is kept, cleared the same way.
- When not defined: overrun tied to 0, no counter logic.

Test Plan:
- Continuous capture: DEPTH=16, decim=0. rst, arm, trigger, then sample_valid held 1 with sample_in = k for k=0..20.
  - Expect exactly 16 mem_we cycles, mem_addr 0..15, mem_wdata 0..15.
  - frame_done high one cycle after the address-15 write.
  - frame_ready=1, sample_count=16, no further writes.
- Decimation: DEPTH=16, decim=2, sample_in = k for k=0..47 continuous.
  - Expect writes of 0,3,6,...,45 at addresses 0..15.
- Gapped valid: DEPTH=16, decim=0, sample_valid toggling 1,0,1,0.
  - Expect a write one cycle after each valid only; data matches the accepted samples in order; 16 writes total.
- Ignored controls:
  - trigger in IDLE -> no state change, busy=0.
  - arm mid-CAPTURE -> frame continues unchanged.
  - trigger in DONE -> no writes.
- Reset mid-frame: rst after the 7th write.
  - Next cycle mem_we=0, busy=0, sample_count=0, no frame_done.
  - Re-arm and trigger -> first write at address 0.
- With CAPTURE_OVERRUN_EN: after a full frame, drive 3 sample_valid cycles in DONE.
  - Expect overrun=1 and drop count=3, no mem_we.
  - arm -> overrun=0 next cycle.
